i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 62 ++++++
 rtl/i2c_tick_gen.sv | 29 ++
 rtl/i2c_master.sv | 173 +++++++++++++++++
 tb/tb_i2c_master.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C register-access master.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned CNT_W     = 12;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef logic [1:0] quarter_t;
  localparam quarter_t Q0 = 2'd0;
  localparam quarter_t Q1 = 2'd1;
  localparam quarter_t Q2 = 2'd2;
  localparam quarter_t Q3 = 2'd3;

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ACK_DEV, REG, ACK_REG, WDATA, ACK_WDATA,
    RSTART, DEV_R, ACK_DEVR, RDATA, MNACK, STOP
  } i2c_state_t;

  // Byte shifted out by the master in a given transmit state
  function automatic logic [BYTE_W-1:0] tx_byte(input i2c_state_t st,
                                                input logic [ADDR_W-1:0] dev,
                                                input logic [BYTE_W-1:0] reg_a,
                                                input logic [BYTE_W-1:0] wd);
    logic [BYTE_W-1:0] b;
    case (st)
      DEV_W:   b = {dev, I2C_RW_WRITE};
      REG:     b = reg_a;
      WDATA:   b = wd;
      DEV_R:   b = {dev, I2C_RW_READ};
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic i2c_state_t byte_next(input i2c_state_t st);
    i2c_state_t n;
    case (st)
      DEV_W:   n = ACK_DEV;
      REG:     n = ACK_REG;
      WDATA:   n = ACK_WDATA;
      DEV_R:   n = ACK_DEVR;
      default: n = MNACK;
    endcase
    return n;
  endfunction

  function automatic i2c_state_t ack_next(input i2c_state_t st, input logic rw);
    i2c_state_t n;
    case (st)
      ACK_DEV:  n = REG;
      ACK_REG:  n = (rw == I2C_RW_READ) ? RSTART : WDATA;
      ACK_DEVR: n = RDATA;
      default:  n = STOP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator; counter freezes while hold is high.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic hold,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  // Tick is registered one count early so it lands exactly every CLK_DIV cycles
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(CLK_DIV - 2));
      cnt  <= (cnt == CNT_W'(CLK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C register write/read master with open-drain line control.
// Optional I2C_MASTER_CLK_STRETCH_EN: wait for SCL to read high after release.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] dev_addr,
  input  logic [BYTE_W-1:0] reg_addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  input  logic              SDA_i,
  input  logic              SCL_i,
  output logic              SDA_t,
  output logic              SCL_t,
  output logic              SDA_o,
  output logic              SCL_o
);

  i2c_state_t             state;
  quarter_t               q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   rw_q;
  logic [ADDR_W-1:0]      dev_q;
  logic [BYTE_W-1:0]      reg_q;
  logic [BYTE_W-1:0]      wdata_q;
  logic [BYTE_W-1:0]      rx_shift;
  logic [BYTE_W-1:0]      cur_byte;
  logic                   nack_seen;
  logic                   tick;
  logic                   hold;

  assign SDA_o    = 1'b0;
  assign SCL_o    = 1'b0;
  assign cur_byte = tx_byte(state, dev_q, reg_q, wdata_q);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign hold = busy && SCL_t && !SCL_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = SCL_i;
  assign hold         = 1'b0;
`endif

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (busy),
    .hold   (hold),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      q         <= Q0;
      bit_cnt   <= 3'd7;
      rw_q      <= I2C_RW_WRITE;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rx_shift  <= '0;
      nack_seen <= 1'b0;
      SDA_t     <= 1'b1;
      SCL_t     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // START condition: SDA falls immediately while SCL is still released
        if (start) begin
          state     <= START;
          q         <= Q0;
          bit_cnt   <= 3'd7;
          rw_q      <= rw;
          dev_q     <= dev_addr;
          reg_q     <= reg_addr;
          wdata_q   <= wdata;
          rx_shift  <= '0;
          nack_seen <= 1'b0;
          ack_err   <= 1'b0;
          busy      <= 1'b1;
          SDA_t     <= 1'b0;
        end
      end else if (state == STOP && done) begin
        state <= IDLE;
      end else if (tick) begin
        q <= q + 2'd1;
        case (state)
          START: begin
            SCL_t <= 1'b0;
            q     <= Q0;
            state <= DEV_W;
          end
          DEV_W, REG, WDATA, DEV_R, RDATA: begin
            case (q)
              Q0: SDA_t <= (state == RDATA) ? 1'b1 : cur_byte[bit_cnt];
              Q1: SCL_t <= 1'b1;
              Q2: if (state == RDATA) rx_shift <= {rx_shift[BYTE_W-2:0], SDA_i};
              default: begin
                SCL_t <= 1'b0;
                if (bit_cnt == 3'd0) begin
                  bit_cnt <= 3'd7;
                  state   <= byte_next(state);
                end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                end
              end
            endcase
          end
          ACK_DEV, ACK_REG, ACK_WDATA, ACK_DEVR: begin
            case (q)
              Q0: SDA_t <= 1'b1;
              Q1: SCL_t <= 1'b1;
              Q2: if (SDA_i) nack_seen <= 1'b1;
              default: begin
                SCL_t <= 1'b0;
                state <= nack_seen ? STOP : ack_next(state, rw_q);
              end
            endcase
          end
          RSTART: begin
            case (q)
              Q0: SDA_t <= 1'b1;
              Q1: SCL_t <= 1'b1;
              Q2: SDA_t <= 1'b0;
              default: begin
                SCL_t <= 1'b0;
                state <= DEV_R;
              end
            endcase
          end
          MNACK: begin
            case (q)
              Q0: SDA_t <= 1'b1;
              Q1: SCL_t <= 1'b1;
              Q2: ;
              default: begin
                SCL_t <= 1'b0;
                state <= STOP;
              end
            endcase
          end
          STOP: begin
            case (q)
              Q0: SDA_t <= 1'b0;
              Q1: SCL_t <= 1'b1;
              Q2: SDA_t <= 1'b1;
              default: begin
                done    <= 1'b1;
                busy    <= 1'b0;
                ack_err <= nack_seen;
                if (rw_q == I2C_RW_READ) rdata <= rx_shift;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a bus monitor and a single-register slave model.
module tb_i2c_master;
  import i2c_pkg::*;

  localparam int D         = 8;
  localparam int T_WR      = 113 * D + 1;
  localparam int T_RD      = 153 * D + 1;
  localparam int T_NACK    = 41 * D + 1;
  localparam int LIMIT     = 200 * D + 2000;
  localparam int EV_START  = 'h200;
  localparam int EV_RSTART = 'h300;
  localparam int EV_STOP   = 'h400;
  localparam logic [6:0] SLV_ADDR = 7'h30;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  localparam int STRETCH_EXTRA = 500;
`else
  localparam int STRETCH_EXTRA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  logic       SDA_i, SCL_i, SDA_t, SCL_t, SDA_o, SCL_o;

  logic       slv_sda = 1'b1;
  int         stretch_left = 0;
  logic       stretch_en = 1'b0;
  logic [7:0] rd_val = 8'h3C;

  int n_tests = 0;
  int n_fail  = 0;
  int ev[$];

  assign SDA_i = SDA_t & slv_sda;
  assign SCL_i = SCL_t & (stretch_left == 0);

  always #5 clock = ~clock;

  i2c_master #(.CLK_DIV(D)) dut (
    .clock(clock), .reset(reset), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err),
    .SDA_i(SDA_i), .SCL_i(SCL_i), .SDA_t(SDA_t), .SCL_t(SCL_t),
    .SDA_o(SDA_o), .SCL_o(SCL_o)
  );

  // Monitor keys on the master's own SCL intent so bit capture is independent of stretching
  logic       sda_p = 1'b1, scl_p = 1'b1;
  int         nb = 0, frame = 0;
  logic [7:0] sh = '0;
  logic       act = 1'b0, first = 1'b0, sel = 1'b0, tx = 1'b0, tx_pend = 1'b0;

  always @(posedge clock) begin
    sda_p <= SDA_i;
    scl_p <= SCL_t;
    if (reset) begin
      act <= 1'b0; nb <= 0; tx <= 1'b0; tx_pend <= 1'b0;
      slv_sda <= 1'b1; stretch_left <= 0;
    end else begin
      if (stretch_left > 0 && SCL_t) stretch_left <= stretch_left - 1;
      if (scl_p && SCL_t && sda_p && !SDA_i) begin
        ev.push_back(act ? EV_RSTART : EV_START);
        act <= 1'b1; nb <= 0; first <= 1'b1; frame <= 0;
        tx <= 1'b0; tx_pend <= 1'b0; slv_sda <= 1'b1;
      end else if (scl_p && SCL_t && !sda_p && SDA_i) begin
        ev.push_back(EV_STOP);
        act <= 1'b0; nb <= 0; tx <= 1'b0; tx_pend <= 1'b0; slv_sda <= 1'b1;
      end else if (!scl_p && SCL_t) begin
        if (nb == 8) begin
          ev.push_back(32'({SDA_i, sh}));
          nb <= 0; frame <= frame + 1; first <= 1'b0; tx <= 1'b0;
          if (first) begin
            sel     <= (sh[7:1] == SLV_ADDR);
            tx_pend <= (sh[7:1] == SLV_ADDR) && sh[0] && !SDA_i;
          end
        end else begin
          sh <= {sh[6:0], SDA_i};
          nb <= nb + 1;
        end
      end else if (scl_p && !SCL_t) begin
        if (nb == 8) begin
          if (tx)         slv_sda <= 1'b1;
          else if (first) slv_sda <= !(sh[7:1] == SLV_ADDR);
          else            slv_sda <= !sel;
        end else if (nb == 0) begin
          if (tx_pend) begin
            tx <= 1'b1; tx_pend <= 1'b0; slv_sda <= rd_val[7];
          end else begin
            slv_sda <= 1'b1;
          end
        end else if (tx) begin
          slv_sda <= rd_val[3'(7 - nb)];
        end
        if (stretch_en && frame == 1 && nb == 4) stretch_left <= 500;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input int exp[$]);
    check({tag, "_events"}, ev.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ev.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), ev[i], exp[i]);
  endtask

  task automatic run_xfer(input logic rw_i, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, input int abort_at, input bit noisy,
                          output int t_done, output int t_scl);
    int n;
    ev.delete();
    rw = rw_i; dev_addr = dev; reg_addr = ra; wdata = wd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; n = 1; t_done = -1; t_scl = -1;
    check("busy_latency", busy, 1);
    check("ack_err_cleared", ack_err, 0);
    while (n < LIMIT) begin
      if (t_scl < 0 && !SCL_t) t_scl = n;
      if (done) begin
        t_done = n;
        break;
      end
      if (n == abort_at) begin
        check("pre_abort_sda", SDA_t, 0);
        check("pre_abort_scl", SCL_t, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_sda_t", SDA_t, 1);
        check("abort_scl_t", SCL_t, 1);
        check("abort_busy", busy, 0);
        check("abort_rdata", rdata, 0);
        return;
      end
      start = (noisy && n == 100);
      @(posedge clock); #1;
      n++;
    end
    start = noisy;
    @(posedge clock); #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    if (noisy) check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    int td, ts, stops;
    int exp_wr[$], exp_rd[$], exp_nk[$];
    exp_wr = '{EV_START, 'h060, 'h012, 'h0A5, EV_STOP};
    exp_rd = '{EV_START, 'h060, 'h012, EV_RSTART, 'h061, 'h13C, EV_STOP};
    exp_nk = '{EV_START, 'h162, EV_STOP};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_sda_t", SDA_t, 1);
    check("rst_scl_t", SCL_t, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_rdata", rdata, 0);
    check("sda_o_low", SDA_o, 0);
    repeat (5) @(posedge clock);
    #1;

    run_xfer(I2C_RW_WRITE, 7'h30, 8'h12, 8'hA5, 0, 1'b0, td, ts);
    check("wr_done_cycles", td, T_WR);
    check("wr_scl_latency", ts, D + 1);
    check("wr_ack_err", ack_err, 0);
    check_bus("wr", exp_wr);
    repeat (4) @(posedge clock);
    #1;

    run_xfer(I2C_RW_READ, 7'h30, 8'h12, 8'h00, 0, 1'b0, td, ts);
    check("rd_done_cycles", td, T_RD);
    check("rd_rdata", rdata, 8'h3C);
    check("rd_ack_err", ack_err, 0);
    check_bus("rd", exp_rd);
    repeat (4) @(posedge clock);
    #1;

    run_xfer(I2C_RW_WRITE, 7'h31, 8'h12, 8'hA5, 0, 1'b0, td, ts);
    check("nack_done_cycles", td, T_NACK);
    check("nack_ack_err", ack_err, 1);
    check("nack_rdata_kept", rdata, 8'h3C);
    check_bus("nack", exp_nk);
    repeat (4) @(posedge clock);
    #1;

    stretch_en = 1'b1;
    run_xfer(I2C_RW_WRITE, 7'h30, 8'h12, 8'hA5, 0, 1'b0, td, ts);
    stretch_en = 1'b0;
    check("stretch_done_cycles", td, T_WR + STRETCH_EXTRA);
    check("stretch_ack_err", ack_err, 0);
    check_bus("stretch", exp_wr);
    repeat (4) @(posedge clock);
    #1;

    run_xfer(I2C_RW_WRITE, 7'h30, 8'h12, 8'hA5, 86 * D + 3, 1'b0, td, ts);
    repeat (10) @(posedge clock);
    #1;
    stops = 0;
    foreach (ev[i]) if (ev[i] == EV_STOP) stops++;
    check("abort_no_stop", stops, 0);

    run_xfer(I2C_RW_WRITE, 7'h30, 8'h12, 8'hA5, 0, 1'b1, td, ts);
    check("post_abort_done_cycles", td, T_WR);
    check("post_abort_ack_err", ack_err, 0);
    repeat (4 * D) @(posedge clock);
    #1;
    check("noisy_stays_idle", busy, 0);
    check_bus("noisy", exp_wr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
